// File: rtl/custom_pkg.sv
// rtl/custom_pkg.sv - register map, CTRL/STATUS bit positions and capture modes
package custom_pkg;

  localparam logic [19:0] REG_LED     = 20'h00;
  localparam logic [19:0] REG_CTRL    = 20'h04;
  localparam logic [19:0] REG_STATUS  = 20'h08;
  localparam logic [19:0] REG_LEVEL   = 20'h0C;
  localparam logic [19:0] REG_PRESC   = 20'h10;
  localparam logic [19:0] REG_DATA_LO = 20'h14;
  localparam logic [19:0] REG_DATA_HI = 20'h18;
  localparam logic [19:0] REG_CNT_LO  = 20'h1C;

  localparam int CTRL_CLR  = 0;
  localparam int CTRL_EN   = 1;
  localparam int CTRL_MODE = 2;
  localparam int CTRL_SOF  = 3;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_WRAP  = 3;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_EVENT    = 1'b1
  } cap_mode_e;

endpackage

// File: rtl/ts_fifo_sync.sv
// rtl/ts_fifo_sync.sv - single-clock first-word-fall-through FIFO
// Storage array holds the body; head_q is prefetched so the front entry is visible without a read strobe.
module ts_fifo_sync #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      head_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q, rd_next;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  push_ok, pop_ok;

  assign full_o  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign head_o  = head_q;

  // A pop frees a slot, so a push is still accepted when full.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_i);
  assign rd_next = pop_ok ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;

  always_ff @(posedge clk_i) begin
    if (push_ok && !clr_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      rd_ptr_q <= rd_next;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (DEPTH_LOG2+1)'(1);
        2'b01:   count_q <= count_q - (DEPTH_LOG2+1)'(1);
        default: count_q <= count_q;
      endcase
      // Writing the slot about to become head: the array read would return stale data.
      head_q <= (push_ok && (wr_ptr_q == rd_next)) ? data_i : mem_q[rd_next];
    end
  end

endmodule

// File: rtl/timestamp_capture_fifo.sv
// rtl/timestamp_capture_fifo.sv - prescaled timestamp counter with periodic/event capture FIFO
module timestamp_capture_fifo
  import custom_pkg::*;
#(
  parameter int CNT_W      = 64,
  parameter int DEPTH_LOG2 = 10,
  parameter int PRESC_W    = 16,
  parameter int LED_W      = 8
) (
  input  logic             sys_clk_i,
  input  logic             sys_rstn_i,
  input  logic [31:0]      sys_addr_i,
  input  logic [31:0]      sys_wdata_i,
  input  logic [3:0]       sys_sel_i,
  input  logic             sys_wen_i,
  input  logic             sys_ren_i,
  output logic [31:0]      sys_rdata_o,
  output logic             sys_err_o,
  output logic             sys_ack_o,
  input  logic             evt_i,
  output logic [LED_W-1:0] led_o
);

  logic [LED_W-1:0]   led_q, led_d;
  logic               en_q, en_d, sof_q, sof_d;
  cap_mode_e          mode_q, mode_d;
  logic [PRESC_W-1:0] presc_q, presc_d, psc_q, psc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d, wrap_q, wrap_d;
  logic [31:0]        shadow_q, shadow_d, rdata_q, rdata_d;
  logic               ack_q;
  logic [2:0]         evt_q;

  logic [19:0]        addr;
  logic               clr, tick, evt_rise, push, pop, drop, mapped;
  logic [CNT_W-1:0]   head;
  logic               full, empty;
  logic [DEPTH_LOG2:0] level;
  logic               unused_bits;

  assign addr        = sys_addr_i[19:0];
  assign unused_bits = ^{sys_sel_i, sys_addr_i[31:20], sys_wdata_i};
  assign mapped      = addr inside {REG_LED, REG_CTRL, REG_STATUS, REG_LEVEL,
                                    REG_PRESC, REG_DATA_LO, REG_DATA_HI, REG_CNT_LO};

  assign clr      = sys_wen_i && (addr == REG_CTRL) && sys_wdata_i[CTRL_CLR];
  assign tick     = en_q && (psc_q == presc_q);
  assign evt_rise = evt_q[1] && !evt_q[2];
  assign push     = en_q && ((mode_q == MODE_PERIODIC) ? tick : evt_rise);
  assign pop      = sys_ren_i && (addr == REG_DATA_LO);
  assign drop     = push && full && !pop;

  ts_fifo_sync #(.WIDTH(CNT_W), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk_i   (sys_clk_i),
    .rst_ni  (sys_rstn_i),
    .clr_i   (clr),
    .push_i  (push),
    .data_i  (cnt_q),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  always_comb begin
    led_d    = led_q;
    en_d     = en_q;
    mode_d   = mode_q;
    sof_d    = sof_q;
    presc_d  = presc_q;
    psc_d    = psc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    wrap_d   = wrap_q;
    shadow_d = shadow_q;
    if (en_q) begin
      psc_d = tick ? '0 : psc_q + PRESC_W'(1);
      if (tick) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (&cnt_q) wrap_d = 1'b1;
      end
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (sof_q) en_d = 1'b0;
    end
    if (pop) shadow_d = empty ? '0 : 32'(head[CNT_W-1:32]);
    if (sys_wen_i) begin
      case (addr)
        REG_LED:   led_d = sys_wdata_i[LED_W-1:0];
        REG_CTRL: begin
          en_d   = sys_wdata_i[CTRL_EN];
          mode_d = cap_mode_e'(sys_wdata_i[CTRL_MODE]);
          sof_d  = sys_wdata_i[CTRL_SOF];
        end
        REG_PRESC: presc_d = sys_wdata_i[PRESC_W-1:0];
        default: ;
      endcase
    end
    // Clear beats every concurrent update except the EN/MODE/SOF fields of the same write.
    if (clr) begin
      psc_d    = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      wrap_d   = 1'b0;
      shadow_d = '0;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (sys_ren_i) begin
      case (addr)
        REG_LED:    rdata_d = 32'(led_q);
        REG_CTRL: begin
          rdata_d[CTRL_EN]   = en_q;
          rdata_d[CTRL_MODE] = mode_q;
          rdata_d[CTRL_SOF]  = sof_q;
        end
        REG_STATUS: begin
          rdata_d[ST_EMPTY] = empty;
          rdata_d[ST_FULL]  = full;
          rdata_d[ST_OVF]   = ovf_q;
          rdata_d[ST_WRAP]  = wrap_q;
        end
        REG_LEVEL:   rdata_d = 32'(level);
        REG_PRESC:   rdata_d = 32'(presc_q);
        REG_DATA_LO: rdata_d = empty ? '0 : head[31:0];
        REG_DATA_HI: rdata_d = shadow_q;
        REG_CNT_LO:  rdata_d = cnt_q[31:0];
        default:     rdata_d = '1;
      endcase
    end else if (sys_wen_i && !mapped) begin
      rdata_d = '1;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      led_q    <= '0;
      en_q     <= 1'b0;
      mode_q   <= MODE_PERIODIC;
      sof_q    <= 1'b0;
      presc_q  <= '0;
      psc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      wrap_q   <= 1'b0;
      shadow_q <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      evt_q    <= '0;
    end else begin
      led_q    <= led_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      sof_q    <= sof_d;
      presc_q  <= presc_d;
      psc_q    <= psc_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      wrap_q   <= wrap_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
      ack_q    <= sys_wen_i || sys_ren_i;
      evt_q    <= {evt_q[1:0], evt_i};
    end
  end

  assign sys_rdata_o = rdata_q;
  assign sys_ack_o   = ack_q;
  assign sys_err_o   = 1'b0;
  assign led_o       = led_q;

endmodule

// File: tb/tb_timestamp_capture_fifo.sv
// tb/tb_timestamp_capture_fifo.sv - directed bench for timestamp_capture_fifo
module tb_timestamp_capture_fifo;

  localparam int CNT_W      = 40;
  localparam int DEPTH_LOG2 = 4;
  localparam int PRESC_W    = 16;
  localparam int LED_W      = 8;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [31:0]      addr = '0;
  logic [31:0]      wdata = '0;
  logic [3:0]       sel = 4'hF;
  logic             wen = 1'b0;
  logic             ren = 1'b0;
  logic             evt = 1'b0;
  logic [31:0]      rdata;
  logic             err;
  logic             ack;
  logic [LED_W-1:0] led;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rd_val;
  logic        rd_ack;

  timestamp_capture_fifo #(
    .CNT_W(CNT_W), .DEPTH_LOG2(DEPTH_LOG2), .PRESC_W(PRESC_W), .LED_W(LED_W)
  ) dut (
    .sys_clk_i   (clk),
    .sys_rstn_i  (rstn),
    .sys_addr_i  (addr),
    .sys_wdata_i (wdata),
    .sys_sel_i   (sel),
    .sys_wen_i   (wen),
    .sys_ren_i   (ren),
    .sys_rdata_o (rdata),
    .sys_err_o   (err),
    .sys_ack_o   (ack),
    .evt_i       (evt),
    .led_o       (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic k);
    addr = a;
    ren  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ren = 1'b0;
    d   = rdata;
    k   = ack;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus_rd(a, rd_val, rd_ack);
    check(tag, {32'd0, rd_val}, {32'd0, exp});
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wen = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_led", {56'd0, led}, 64'd0);
    check("rst_ack", {63'd0, ack}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // reset register values and unmapped access
    rd_chk("t1_led", 32'h00, 32'h0);
    rd_chk("t1_ctrl", 32'h04, 32'h0);
    rd_chk("t1_status", 32'h08, 32'h1);
    rd_chk("t1_level", 32'h0C, 32'h0);
    rd_chk("t1_presc", 32'h10, 32'h0);
    rd_chk("t1_data_lo", 32'h14, 32'h0);
    rd_chk("t1_data_hi", 32'h18, 32'h0);
    rd_chk("t1_cnt_lo", 32'h1C, 32'h0);
    rd_chk("t1_unmapped", 32'h40, 32'hFFFF_FFFF);
    check("t1_unmapped_ack", {63'd0, rd_ack}, 64'd1);
    @(negedge clk);
    check("t1_idle_ack", {63'd0, ack}, 64'd0);
    bus_wr(32'h00, 32'h0000_00A5);
    check("t1_led_o", {56'd0, led}, 64'hA5);
    rd_chk("t1_led_rb", 32'h00, 32'hA5);

    // periodic capture with PRESC=3: one push every 4 cycles
    bus_wr(32'h10, 32'd3);
    bus_wr(32'h04, 32'h3);
    repeat (40) @(negedge clk);
    bus_wr(32'h04, 32'h0);
    rd_chk("t2_level", 32'h0C, 32'd10);
    for (int i = 0; i < 10; i++) begin
      rd_chk($sformatf("t2_lo%0d", i), 32'h14, i);
      rd_chk($sformatf("t2_hi%0d", i), 32'h18, 32'h0);
    end
    rd_chk("t2_status", 32'h08, 32'h1);

    // fill to full, overflow, stop-on-full
    bus_wr(32'h10, 32'd0);
    bus_wr(32'h04, 32'hB);
    repeat (20) @(negedge clk);
    rd_chk("t3_status", 32'h08, 32'h6);
    rd_chk("t3_ctrl", 32'h04, 32'h8);
    rd_chk("t3_level", 32'h0C, 32'd16);
    rd_chk("t3_cnt", 32'h1C, 32'd17);
    rd_chk("t3_lo0", 32'h14, 32'd0);
    rd_chk("t3_level_pop", 32'h0C, 32'd15);

    // event capture: rises 50 cycles apart
    bus_wr(32'h04, 32'h7);
    repeat (99) @(negedge clk);
    evt = 1'b1;
    repeat (2) @(negedge clk);
    evt = 1'b0;
    repeat (48) @(negedge clk);
    evt = 1'b1;
    repeat (2) @(negedge clk);
    evt = 1'b0;
    repeat (5) @(negedge clk);
    bus_wr(32'h04, 32'h0);
    rd_chk("t4_level", 32'h0C, 32'd2);
    rd_chk("t4_evt0", 32'h14, 32'd101);
    rd_chk("t4_evt1", 32'h14, 32'd151);
    rd_chk("t4_status", 32'h08, 32'h1);

    // counter wrap with 40-bit counter
    bus_wr(32'h04, 32'h1);
    force dut.cnt_q = 40'hFF_FFFF_FFFE;
    @(negedge clk);
    release dut.cnt_q;
    bus_wr(32'h04, 32'h2);
    repeat (2) @(negedge clk);
    bus_wr(32'h04, 32'h0);
    rd_chk("t5_status", 32'h08, 32'h8);
    rd_chk("t5_level", 32'h0C, 32'd3);
    rd_chk("t5_lo0", 32'h14, 32'hFFFF_FFFE);
    rd_chk("t5_hi0", 32'h18, 32'hFF);
    rd_chk("t5_lo1", 32'h14, 32'hFFFF_FFFF);
    rd_chk("t5_hi1", 32'h18, 32'hFF);
    rd_chk("t5_lo2", 32'h14, 32'h0);
    rd_chk("t5_hi2", 32'h18, 32'h0);
    rd_chk("t5_lo_empty", 32'h14, 32'h0);
    rd_chk("t5_hi_empty", 32'h18, 32'h0);
    rd_chk("t5_cnt", 32'h1C, 32'd1);

    // pop coincident with push at full, then async reset mid-run
    bus_wr(32'h04, 32'h3);
    repeat (25) @(negedge clk);
    rd_chk("t6_status", 32'h08, 32'h6);
    rd_chk("t6_lo0", 32'h14, 32'd0);
    rd_chk("t6_level", 32'h0C, 32'd16);
    rd_chk("t6_lo1", 32'h14, 32'd1);
    rd_chk("t6_level2", 32'h0C, 32'd16);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("t6_rst_led", {56'd0, led}, 64'd0);
    check("t6_rst_ack", {63'd0, ack}, 64'd0);
    check("t6_rst_rdata", {32'd0, rdata}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    rd_chk("t6_level_rst", 32'h0C, 32'd0);
    rd_chk("t6_status_rst", 32'h08, 32'h1);
    rd_chk("t6_ctrl_rst", 32'h04, 32'h0);
    rd_chk("t6_cnt_rst", 32'h1C, 32'h0);
    rd_chk("t6_led_rst", 32'h00, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
